// File: rtl/emu_scan_pkg.sv
// emu_scan_pkg: shared state encoding, scan direction constants and counter sizing
package emu_scan_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PAUSE, S_FF, S_RAM, S_DONE} state_t;
  localparam logic SCAN_DUMP = 1'b0;
  localparam logic SCAN_RESTORE = 1'b1;
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/emu_scan_beat_counter.sv
// emu_scan_beat_counter: beat counter that self-clears on its terminal count
module emu_scan_beat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic         tc
);
  logic [W-1:0] cnt;
  assign tc = cnt == last;
  always_ff @(posedge clk)
    if (!resetn || clr || (inc && tc)) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/emu_scan_ctrl.sv
// emu_scan_ctrl: checkpoint dump/restore sequencer (halt, FF chain, RAM chain).
// The RAM phase exists only when EMU_SCAN_RAM_EN is defined.
module emu_scan_ctrl
  import emu_scan_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int FF_WORDS = 4,
  parameter int RAM_WORDS = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  halt_req,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  emu_halt,
  output logic                  ff_scan,
  output logic [DATA_WIDTH-1:0] ff_sdi,
  input  logic [DATA_WIDTH-1:0] ff_sdo,
  output logic                  ram_scan,
  output logic                  ram_dir,
  output logic [DATA_WIDTH-1:0] ram_sdi,
  input  logic [DATA_WIDTH-1:0] ram_sdo
);
  localparam int CW = cnt_width(FF_WORDS, RAM_WORDS);
  state_t state, nxt;
  logic dir, fire, tc, in_ff, in_ram, last_beat;
  logic [CW-1:0] last;
  assign in_ff = state == S_FF;
`ifdef EMU_SCAN_RAM_EN
  localparam state_t FF_NEXT = S_RAM;
  assign in_ram = state == S_RAM;
  assign last = in_ram ? CW'(RAM_WORDS - 1) : CW'(FF_WORDS - 1);
  assign last_beat = in_ram && tc;
  assign ram_dir = dir;
`else
  localparam state_t FF_NEXT = S_DONE;
  logic unused_ram;
  assign unused_ram = ^ram_sdo;
  assign in_ram = 1'b0;
  assign last = CW'(FF_WORDS - 1);
  assign last_beat = in_ff && tc;
  assign ram_dir = 1'b0;
`endif
  assign fire = (in_ff || in_ram) && (dir ? in_valid : out_ready);
  assign cmd_ready = state == S_IDLE;
  assign busy = !cmd_ready;
  assign done = state == S_DONE;
  assign emu_halt = halt_req || busy;
  always_ff @(posedge clk)
    if (!resetn) begin
      state <= S_IDLE;
      dir <= SCAN_DUMP;
      err <= 1'b0;
    end else begin
      state <= nxt;
      if (cmd_ready && cmd_valid) begin
        dir <= cmd_dir;
        err <= 1'b0;
      end else if (fire && dir == SCAN_RESTORE && in_last != last_beat) err <= 1'b1;
    end
  // Counter is held at zero while idle, so every operation starts from beat 0.
  emu_scan_beat_counter #(.W(CW)) u_cnt (
    .clk(clk),
    .resetn(resetn),
    .clr(cmd_ready),
    .inc(fire),
    .last(last),
    .tc(tc)
  );
  always_comb begin
    nxt = state;
    out_valid = 1'b0;
    in_ready = 1'b0;
    out_data = '0;
    out_last = 1'b0;
    ff_scan = 1'b0;
    ff_sdi = '0;
    ram_scan = 1'b0;
    ram_sdi = '0;
    case (state)
      S_IDLE: nxt = cmd_valid ? S_PAUSE : S_IDLE;
      S_PAUSE: nxt = S_FF;
      S_FF: begin
        out_valid = !dir;
        in_ready = dir;
        out_data = dir ? '0 : ff_sdo;
        out_last = !dir && last_beat;
        ff_scan = fire;
        ff_sdi = dir ? in_data : ff_sdo;
        nxt = (fire && tc) ? FF_NEXT : S_FF;
      end
`ifdef EMU_SCAN_RAM_EN
      S_RAM: begin
        out_valid = !dir;
        in_ready = dir;
        out_data = dir ? '0 : ram_sdo;
        out_last = !dir && last_beat;
        ram_scan = fire;
        ram_sdi = dir ? in_data : '0;
        nxt = (fire && tc) ? S_DONE : S_RAM;
      end
`endif
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
endmodule
